// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared types and helpers for the management-UART transmit arbiter and
//   its round-robin picker (also usable by other small arbiters).
//   Contents:
//     arb_state_t      - arbiter FSM state encoding (idle / packet granted)
//     DEFAULT_TIMEOUT  - default starved-cycle limit before a grant is revoked
//     rr_wrap()        - rotated requester index, wrapping modulo the count
package uart_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 1024;

    // Index of the requester k positions after 'base' in a ring of n.
    // Callers keep base < n and 1 <= k <= n, so one conditional subtract
    // replaces a general modulo.
    function automatic int rr_wrap(input int base_plus_k, input int n);
        return (base_plus_k >= n) ? base_plus_k - n : base_plus_k;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
//   Combinational round-robin picker. Scans the request vector starting at
//   the requester just after last_grant, wrapping around, and reports the
//   first one found.
//   Ports:
//     req        in  NREQ  request vector
//     last_grant in  IDW   most recently served requester
//     winner     out IDW   selected requester (0 when none requests)
//     any        out 1     at least one request is set
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [IDW-1:0]  winner,
    output logic            any
);

    logic [IDW-1:0] cand;

    // Walk from the farthest position back to the nearest; the last hit
    // written is therefore the nearest requester after last_grant.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'(rr_wrap(int'(last_grant) + k, NREQ));
            if (req[cand]) begin
                winner = cand;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART byte serializer between NREQ byte-stream requesters.
//   Whole packets are granted atomically (first byte through the byte marked
//   last), packets are served round-robin, and a watchdog revokes a grant
//   whose owner stops supplying bytes mid-packet.
//   Ports:
//     clock       in  1        system clock
//     resetb      in  1        asynchronous active-low reset
//     req_valid   in  NREQ     per-requester byte valid
//     req_data    in  NREQ*DW  per-requester byte, requester i at [i*DW +: DW]
//     req_last    in  NREQ     byte closes the packet
//     req_ready   out NREQ     per-requester accept (only the grantee)
//     tx_valid    out 1        byte valid to serializer
//     tx_data     out DW       byte to serializer
//     tx_ready    in  1        serializer accept
//     grant_id    out IDW      current or most recent grantee
//     busy        out 1        a packet is granted
//     timeout_evt out 1        one-cycle pulse when the watchdog revokes a grant
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NREQ    = 2,
    parameter  int DW      = 8,
    parameter  int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_valid,
    output logic [DW-1:0]     tx_data,
    input  logic              tx_ready,
    output logic [IDW-1:0]    grant_id,
    output logic              busy,
    output logic              timeout_evt
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] STALL_LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t     state_reg;
    logic [IDW-1:0] grant_id_reg;
    logic [IDW-1:0] last_grant_reg;
    logic           busy_reg;
    logic           timeout_evt_reg;
    logic [CW-1:0]  stall_cnt_reg;

    logic           granted;
    logic           sel_valid;
    logic           sel_last;
    logic [DW-1:0]  sel_data;
    logic           xfer;
    logic           stall_hit;
    logic [IDW-1:0] pick_winner;
    logic           pick_any;

    uart_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .winner     (pick_winner),
        .any        (pick_any)
    );

    // Grantee's byte stream is passed straight through to the serializer;
    // everything is gated by the state register so reset clears it at once.
    assign granted   = (state_reg == ARB_GRANT);
    assign sel_valid = req_valid[grant_id_reg];
    assign sel_last  = req_last[grant_id_reg];
    assign sel_data  = req_data[int'(grant_id_reg)*DW +: DW];

    assign tx_valid  = granted && sel_valid;
    assign tx_data   = granted ? sel_data : '0;
    assign xfer      = tx_valid && tx_ready;

    // Only an absent byte counts as starvation; serializer backpressure
    // with a byte offered never trips the watchdog.
    assign stall_hit = (TIMEOUT > 0) && granted && !sel_valid
                       && (stall_cnt_reg == STALL_LIMIT);

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = granted && (grant_id_reg == IDW'(gi)) && tx_ready;
        end
    endgenerate

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_reg       <= ARB_IDLE;
            grant_id_reg    <= '0;
            last_grant_reg  <= IDW'(NREQ - 1);
            busy_reg        <= 1'b0;
            timeout_evt_reg <= 1'b0;
            stall_cnt_reg   <= '0;
        end else begin
            timeout_evt_reg <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    stall_cnt_reg <= '0;
                    if (pick_any) begin
                        state_reg    <= ARB_GRANT;
                        grant_id_reg <= pick_winner;
                        busy_reg     <= 1'b1;
                    end
                end
                ARB_GRANT: begin
                    if (xfer) begin
                        stall_cnt_reg <= '0;
                        if (sel_last) begin
                            state_reg      <= ARB_IDLE;
                            last_grant_reg <= grant_id_reg;
                            busy_reg       <= 1'b0;
                        end
                    end else if (sel_valid) begin
                        stall_cnt_reg <= '0;
                    end else if (stall_hit) begin
                        // Revoke; any remaining bytes re-arbitrate as a new packet.
                        state_reg       <= ARB_IDLE;
                        last_grant_reg  <= grant_id_reg;
                        busy_reg        <= 1'b0;
                        timeout_evt_reg <= 1'b1;
                        stall_cnt_reg   <= '0;
                    end else if ((TIMEOUT > 0) && (stall_cnt_reg != '1)) begin
                        stall_cnt_reg <= stall_cnt_reg + CW'(1);
                    end
                end
            endcase
        end
    end

    assign grant_id    = grant_id_reg;
    assign busy        = busy_reg;
    assign timeout_evt = timeout_evt_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } src_t;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetb;

    // DUT A: two requesters, short watchdog
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        grant_id;
    logic        busy;
    logic        timeout_evt;

    // DUT B: three requesters, default watchdog
    logic [2:0]  b_req_valid;
    logic [23:0] b_req_data;
    logic [2:0]  b_req_last;
    logic [2:0]  b_req_ready;
    logic        b_tx_valid;
    logic [7:0]  b_tx_data;
    logic        b_tx_ready;
    logic [1:0]  b_grant_id;
    logic        b_busy;
    logic        b_timeout_evt;

    src_t src0_q[$];
    src_t src1_q[$];
    exp_t exp_q[$];
    exp_t exp_b[$];
    int   xfer_log[$];
    int   to_log[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic idle_pend = 1'b0;
    logic [1:0] acc;

    uart_tx_arbiter #(.NREQ(2), .DW(8), .TIMEOUT(16)) dut (
        .clock       (clock),
        .resetb      (resetb),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    uart_tx_arbiter #(.NREQ(3), .DW(8)) dut_b (
        .clock       (clock),
        .resetb      (resetb),
        .req_valid   (b_req_valid),
        .req_data    (b_req_data),
        .req_last    (b_req_last),
        .req_ready   (b_req_ready),
        .tx_valid    (b_tx_valid),
        .tx_data     (b_tx_data),
        .tx_ready    (b_tx_ready),
        .grant_id    (b_grant_id),
        .busy        (b_busy),
        .timeout_evt (b_timeout_evt)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got sim time %0t, want finish before it", $time);
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic send_pkt(input int rq, input int n, input logic [7:0] base);
        src_t s;
        for (int i = 0; i < n; i++) begin
            s.data = base + 8'(i);
            s.last = (i == n - 1);
            if (rq == 0) src0_q.push_back(s);
            else         src1_q.push_back(s);
        end
    endtask

    task automatic expect_pkt(input int rq, input int n, input logic [7:0] base);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.id   = 4'(rq);
            e.data = base + 8'(i);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            #1;
            if (exp_q.size() == 0 && src0_q.size() == 0 && src1_q.size() == 0 && !busy)
                ok = 1'b1;
        end
        check(tag, int'(ok), 1);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 resetb = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetb = 1'b1;
    endtask

    // Requester model + scoreboard monitor for DUT A. Handshakes are sampled
    // on the falling edge; sources advance just after the rising edge.
    initial begin
        exp_t e;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clock);
            acc = req_valid & req_ready;
            if (idle_pend) begin
                idle_pend = 1'b0;
                check("bubble_busy", int'(busy), 0);
                check("bubble_txv", int'(tx_valid), 0);
            end
            if (timeout_evt) begin
                $display("timeout_evt cyc=%0d grant_id=%0d", cyc, grant_id);
                to_log.push_back(cyc);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    $display("xfer cyc=%0d id=%0d data=%02h last=%0d (exp id=%0d data=%02h)",
                             cyc, grant_id, tx_data, req_last[grant_id], e.id, e.data);
                    check("grant_id", int'(grant_id), int'(e.id));
                    check("tx_data", int'(tx_data), int'(e.data));
                    xfer_log.push_back(cyc);
                    if (e.last) idle_pend = 1'b1;
                end
            end
            @(posedge clock);
            #2;
            if (acc[0] && src0_q.size() > 0) src0_q.delete(0);
            if (acc[1] && src1_q.size() > 0) src1_q.delete(0);
            req_valid[0]   = (src0_q.size() > 0);
            req_data[7:0]  = (src0_q.size() > 0) ? src0_q[0].data : 8'h00;
            req_last[0]    = (src0_q.size() > 0) ? src0_q[0].last : 1'b0;
            req_valid[1]   = (src1_q.size() > 0);
            req_data[15:8] = (src1_q.size() > 0) ? src1_q[0].data : 8'h00;
            req_last[1]    = (src1_q.size() > 0) ? src1_q[0].last : 1'b0;
        end
    end

    // Only requester 2 of DUT B sends single-byte packets back to back.
    task automatic run_b();
        exp_t e;
        int   prev;
        logic found;
        logic [7:0] d;
        prev = 0;
        d    = 8'h20;
        @(posedge clock);
        #1;
        b_req_valid = 3'b100;
        b_req_last  = 3'b100;
        b_req_data  = {d, 16'h0000};
        e.id = 4'd2; e.data = d; e.last = 1'b1;
        exp_b.push_back(e);
        for (int k = 0; k < 6; k++) begin
            found = 1'b0;
            for (int w = 0; w < 8 && !found; w++) begin
                @(negedge clock);
                if (b_tx_valid && b_tx_ready) found = 1'b1;
            end
            check("b_wait", int'(found), 1);
            if (!found) break;
            e = exp_b.pop_front();
            $display("b_xfer cyc=%0d id=%0d data=%02h (exp id=%0d data=%02h)",
                     cyc, b_grant_id, b_tx_data, e.id, e.data);
            check("b_grant_id", int'(b_grant_id), int'(e.id));
            check("b_tx_data", int'(b_tx_data), int'(e.data));
            if (k > 0) check("b_period", cyc - prev, 2);
            prev = cyc;
            @(posedge clock);
            #1;
            d = d + 8'h01;
            if (k < 5) begin
                b_req_data = {d, 16'h0000};
                e.data = d;
                exp_b.push_back(e);
            end else begin
                b_req_valid = 3'b000;
            end
        end
        b_req_valid = 3'b000;
        b_req_last  = 3'b000;
    endtask

    initial begin
        resetb      = 1'b0;
        tx_ready    = 1'b1;
        b_req_valid = '0;
        b_req_data  = '0;
        b_req_last  = '0;
        b_tx_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_timeout_evt", int'(timeout_evt), 0);
        check("rst_b_busy", int'(b_busy), 0);
        @(posedge clock);
        #1 resetb = 1'b1;

        // Three-requester DUT, single requester, single-byte packets
        run_b();

        // Single 3-byte packet from requester 0
        @(posedge clock);
        #1;
        xfer_log.delete();
        send_pkt(0, 3, 8'h41);
        expect_pkt(0, 3, 8'h41);
        wait_drain("t1_drain", 40);
        check("t1_count", xfer_log.size(), 3);
        if (xfer_log.size() == 3) check("t1_span", xfer_log[2] - xfer_log[0], 2);

        // Two requesters, two 2-byte packets each, fresh round-robin state
        do_reset();
        xfer_log.delete();
        send_pkt(0, 2, 8'h50);
        send_pkt(0, 2, 8'h60);
        send_pkt(1, 2, 8'h70);
        send_pkt(1, 2, 8'h80);
        expect_pkt(0, 2, 8'h50);
        expect_pkt(1, 2, 8'h70);
        expect_pkt(0, 2, 8'h60);
        expect_pkt(1, 2, 8'h80);
        wait_drain("t2_drain", 60);
        check("t2_count", xfer_log.size(), 8);
        // 4 packets of 2 bytes plus one idle cycle each: 10 cycles first to last byte
        if (xfer_log.size() == 8) check("t2_span", xfer_log[7] - xfer_log[0], 10);

        // Long serializer backpressure with a byte offered: no watchdog
        @(posedge clock);
        #1;
        xfer_log.delete();
        to_log.delete();
        tx_ready = 1'b0;
        send_pkt(1, 1, 8'h90);
        expect_pkt(1, 1, 8'h90);
        repeat (5000) @(posedge clock);
        @(negedge clock);
        check("t3_busy", int'(busy), 1);
        check("t3_grant_id", int'(grant_id), 1);
        check("t3_tx_valid", int'(tx_valid), 1);
        check("t3_no_timeout", to_log.size(), 0);
        @(posedge clock);
        #1 tx_ready = 1'b1;
        wait_drain("t3_drain", 20);

        // Requester 0 stalls mid-packet; watchdog revokes, requester 1 follows
        @(posedge clock);
        #1;
        xfer_log.delete();
        to_log.delete();
        begin
            src_t s;
            exp_t e;
            s.data = 8'hA0; s.last = 1'b0;
            src0_q.push_back(s);
            e.id = 4'd0; e.data = 8'hA0; e.last = 1'b0;
            exp_q.push_back(e);
        end
        send_pkt(1, 1, 8'hB0);
        expect_pkt(1, 1, 8'hB0);
        wait_drain("t4_drain", 80);
        check("t4_timeouts", to_log.size(), 1);
        check("t4_xfers", xfer_log.size(), 2);
        if (to_log.size() == 1 && xfer_log.size() == 2) begin
            // 16 starved cycles after the handshake cycle, then the registered pulse
            check("t4_pulse_delay", to_log[0] - xfer_log[0], 17);
            check("t4_regrant", xfer_log[1] - to_log[0], 1);
        end

        // Reset while requester 1 holds a grant
        @(posedge clock);
        #1;
        tx_ready = 1'b0;
        send_pkt(1, 3, 8'hC0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("t5_pre_busy", int'(busy), 1);
        check("t5_pre_grant_id", int'(grant_id), 1);
        check("t5_pre_tx_valid", int'(tx_valid), 1);
        @(posedge clock);
        #3 resetb = 1'b0;
        #1;
        check("t5_tx_valid", int'(tx_valid), 0);
        check("t5_req_ready", int'(req_ready), 0);
        check("t5_busy", int'(busy), 0);
        @(posedge clock);
        #1;
        tx_ready = 1'b1;
        send_pkt(0, 1, 8'hD0);
        expect_pkt(0, 1, 8'hD0);
        expect_pkt(1, 3, 8'hC0);
        @(posedge clock);
        #1 resetb = 1'b1;
        wait_drain("t5_drain", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
